// File: rtl/mux_arb_pkg.sv
// Shared definitions for the two-channel round-robin mux arbiter.
// Contents: FSM state encodings (IDLE/GNT0/GNT1) and mux select values.
package mux_arb_pkg;

    // FSM state encodings
    localparam int unsigned STATE_W = 2;
    localparam logic [STATE_W-1:0] IDLE = 2'd0;
    localparam logic [STATE_W-1:0] GNT0 = 2'd1;
    localparam logic [STATE_W-1:0] GNT1 = 2'd2;

    // Mux select values
    localparam logic SEL_CH0 = 1'b0;
    localparam logic SEL_CH1 = 1'b1;

endpackage

// File: rtl/mux_arb_skid.sv
// Two-entry skid buffer placed on the arbiter output when
// MUX_RR_ARBITER_OUT_REG_EN is defined. It registers valid and payload
// and takes one beat per cycle for as long as its output is drained.
// Ports:
//   clk, rst_n               clock, async active-low reset (clears to empty)
//   in_valid/in_data/in_ready upstream side; in_ready = "not full"
//   out_valid/out_data/out_ready downstream side, driven from flops
// The module exists only when MUX_RR_ARBITER_OUT_REG_EN is defined.
`ifdef MUX_RR_ARBITER_OUT_REG_EN
module mux_arb_skid #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    localparam int unsigned CNT_W = 2;

    logic [W-1:0]     mem_q [2];
    logic [W-1:0]     mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_c, pop_c;

    assign in_ready  = (cnt_q != CNT_W'(2));
    assign out_valid = (cnt_q != CNT_W'(0));
    assign out_data  = mem_q[rd_ptr_q];
    assign push_c    = in_valid & in_ready;
    assign pop_c     = out_valid & out_ready;

    // Next-state for storage, pointers and fill level
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q ^ push_c;
        rd_ptr_d = rd_ptr_q ^ pop_c;
        cnt_d    = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
        if (push_c) begin
            mem_d[wr_ptr_q] = in_data;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin arbiter feeding a 2:1 data mux. A grant is held
// from the first beat of a packet to its last beat, so packets never
// interleave; rr_ptr moves to the other channel at each packet end.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   in{0,1}_valid/_data/_last/_ready  requester channels (valid/ready)
//   out_valid/out_data/out_last       granted channel towards the consumer
//   out_ready                         consumer accept
//   sel                               mux select (0 = ch0, 1 = ch1)
//   busy                              a grant is held
// Build option: MUX_RR_ARBITER_OUT_REG_EN inserts a 2-entry skid buffer on
// the output (+1 cycle latency, ready path no longer combinational).
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in0_last,
    output logic              in0_ready,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_last,
    output logic              in1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              sel,
    output logic              busy
);

    logic [STATE_W-1:0] state_q, state_d;
    logic               rr_ptr_q, rr_ptr_d;
    logic               gnt0_c, gnt1_c;
    logic               cur_valid_c, cur_last_c, oth_valid_c;
    logic [DATA_W-1:0]  cur_data_c;
    logic               sink_ready_c;
    logic               acc_c;

    assign gnt0_c = (state_q == GNT0);
    assign gnt1_c = (state_q == GNT1);
    assign sel    = gnt1_c ? SEL_CH1 : SEL_CH0;
    assign busy   = gnt0_c | gnt1_c;

    // Granted-channel mux; everything reads as zero while idle
    always_comb begin
        cur_valid_c = 1'b0;
        cur_data_c  = '0;
        cur_last_c  = 1'b0;
        oth_valid_c = 1'b0;
        if (gnt0_c) begin
            cur_valid_c = in0_valid;
            cur_data_c  = in0_data;
            cur_last_c  = in0_last;
            oth_valid_c = in1_valid;
        end else if (gnt1_c) begin
            cur_valid_c = in1_valid;
            cur_data_c  = in1_data;
            cur_last_c  = in1_last;
            oth_valid_c = in0_valid;
        end
    end

    // Readies depend only on the grant and the sink, never on the valids
    assign in0_ready = gnt0_c & sink_ready_c;
    assign in1_ready = gnt1_c & sink_ready_c;
    assign acc_c     = cur_valid_c & sink_ready_c;

`ifdef MUX_RR_ARBITER_OUT_REG_EN
    logic              skid_in_ready;
    logic [DATA_W:0]   skid_out_data;

    // Packet end is seen where the beat enters the skid, not where it leaves
    mux_arb_skid #(
        .W (DATA_W + 1)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (cur_valid_c),
        .in_data   ({cur_last_c, cur_data_c}),
        .in_ready  (skid_in_ready),
        .out_valid (out_valid),
        .out_data  (skid_out_data),
        .out_ready (out_ready)
    );

    assign sink_ready_c = skid_in_ready;
    assign out_last     = skid_out_data[DATA_W];
    assign out_data     = skid_out_data[DATA_W-1:0];
`else
    assign sink_ready_c = out_ready;
    assign out_valid    = cur_valid_c;
    assign out_data     = cur_data_c;
    assign out_last     = cur_last_c;
`endif

    // Grant FSM: arbitrate from IDLE, hold the grant until the last beat
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (in0_valid | in1_valid) begin
                    if (rr_ptr_q == SEL_CH1) begin
                        state_d = in1_valid ? GNT1 : GNT0;
                    end else begin
                        state_d = in0_valid ? GNT0 : GNT1;
                    end
                end
            end
            GNT0, GNT1: begin
                if (acc_c & cur_last_c) begin
                    // Hand straight over when the other side waits; a lone
                    // channel re-arbitrates through IDLE
                    rr_ptr_d = gnt1_c ? SEL_CH0 : SEL_CH1;
                    if (oth_valid_c) begin
                        state_d = gnt1_c ? GNT0 : GNT1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= SEL_CH0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule
